riscy_instr_feeder: RTL

Instruction-side memory responder that sits directly upstream of the RISCY core's instruction fetch port. It buffers instruction words pushed by the UVM driver in an internal FIFO. It answers the core's req/gnt/rvalid fetch handshake with a programmable grant latency and returns one buffered word per granted fetch. The fetch address is exported so the monitor can log the PC stream.

---
 rtl/riscy_feeder_pkg.sv | 33 +++
 rtl/riscy_feeder_fifo.sv | 77 +++++++
 rtl/riscy_instr_feeder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/riscy_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscy_feeder_pkg
// Description : Shared types and constants for the RISCY instruction feeder:
//               instruction word type, default NOP encoding, fetch FSM state
//               encoding and the grant-delay counter load helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscy_feeder_pkg;

    // 32-bit RISC-V instruction word.
    typedef logic [31:0] instr_t;

    // addi x0, x0, 0
    localparam instr_t C_NOP_INSTR = 32'h0000_0013;

    // Fetch FSM state encoding, explicit width.
    localparam int C_STATE_W = 1;
    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

    // The cycle in which req is first seen in IDLE is itself the first idle
    // cycle, so WAIT only has to cover (delay - 1) further cycles before it
    // is allowed to grant. A zero delay that could not be granted at once
    // (nothing available) enters WAIT with a zero count and simply holds.
    function automatic logic [3:0] f_wait_load(input logic [3:0] delay);
        return (delay == 4'd0) ? 4'd0 : delay - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscy_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscy_feeder_fifo
// Description : Synchronous FIFO with flush, occupancy count and full/empty
//               flags. Pushes while full and pops while empty are ignored.
//               Flush has priority over a push in the same cycle.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_flush       - clear contents (pointers and count)
//               i_push/i_wdata- write request and data
//               i_pop         - remove the head entry
//               o_head        - current head entry (valid when !o_empty)
//               o_count       - occupancy, 0..DEPTH
//               o_full/o_empty- status flags
// Revision    : 1.0 - initial release
// ============================================================================
module riscy_feeder_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int              c_ptr_w = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_full);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/riscy_instr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : riscy_instr_feeder
// Description : Instruction-side memory responder for the RISCY fetch port.
//               Buffers driver-pushed instruction words and answers the
//               core's req/gnt/rvalid handshake with a programmable grant
//               latency, returning one buffered word (or NOP) per grant.
// Ports       : clk_i, rst_i          - clock, asynchronous active-high reset
//               inst_valid_i/data_i   - driver push; inst_ready_o = not full
//               instr_req_i/addr_i    - core fetch request and address
//               instr_gnt_o           - combinational grant
//               instr_rvalid_o/rdata_o- registered response, 1 cycle after gnt
//               fetch_addr_o          - address captured at the grant
//               gnt_delay_i           - idle cycles before each grant
//               nop_fill_en_i         - grant with NOP when FIFO is empty
//               flush_i               - clear FIFO, force FSM to IDLE
//               fifo_count_o          - FIFO occupancy
//               protocol_err_o        - sticky: req dropped while waiting
// Revision    : 1.0 - initial release
// ============================================================================
module riscy_instr_feeder
    import riscy_feeder_pkg::*;
#(
    parameter int     DEPTH     = 8,
    parameter instr_t NOP_INSTR = C_NOP_INSTR
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       inst_valid_i,
    input  logic [31:0]                inst_data_i,
    output logic                       inst_ready_o,
    input  logic                       instr_req_i,
    input  logic [31:0]                instr_addr_i,
    output logic                       instr_gnt_o,
    output logic                       instr_rvalid_o,
    output logic [31:0]                instr_rdata_o,
    output logic [31:0]                fetch_addr_o,
    input  logic [3:0]                 gnt_delay_i,
    input  logic                       nop_fill_en_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic                       protocol_err_o
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fsm_state_t        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_rvalid;
    instr_t            r_rdata;
    logic [31:0]       r_fetch_addr;
    logic              r_protocol_err;

    instr_t            w_head;
    logic [c_cnt_w-1:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_avail;
    logic              w_gnt;
    logic              w_pop;

    // The granted word leaves the FIFO on the grant edge itself, so the
    // occupancy already excludes the word owed to the outstanding rvalid;
    // a non-empty FIFO therefore means a word is genuinely available.
    assign w_avail = ~w_empty | nop_fill_en_i;
    assign w_pop   = w_gnt & ~w_empty;

    riscy_feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_flush (flush_i),
        .i_push  (inst_valid_i),
        .i_wdata (inst_data_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Grant is combinational so a zero-delay request is granted in the same
    // cycle. A flush cycle never grants: the FIFO is being emptied under it.
    always_comb begin
        w_gnt = 1'b0;
        if (instr_req_i && w_avail && !flush_i) begin
            case (r_state)
                ST_IDLE: w_gnt = (gnt_delay_i == 4'd0);
                ST_WAIT: w_gnt = (r_wait_cnt == 4'd0);
                default: w_gnt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= 4'd0;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_fetch_addr   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            // Response: one cycle after each grant, never more than one
            // outstanding since the rvalid register is overwritten each cycle.
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata      <= w_empty ? NOP_INSTR : w_head;
                r_fetch_addr <= instr_addr_i;
            end

            if (flush_i) begin
                r_state    <= ST_IDLE;
                r_wait_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (instr_req_i && !w_gnt) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= f_wait_load(gnt_delay_i);
                        end
                    end
                    ST_WAIT: begin
                        if (!instr_req_i) begin
                            r_protocol_err <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else if (r_wait_cnt != 4'd0) begin
                            r_wait_cnt <= r_wait_cnt - 4'd1;
                        end else if (w_gnt) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign inst_ready_o   = ~w_full;
    assign instr_gnt_o    = w_gnt;
    assign instr_rvalid_o = r_rvalid;
    assign instr_rdata_o  = r_rdata;
    assign fetch_addr_o   = r_fetch_addr;
    assign fifo_count_o   = w_count;
    assign protocol_err_o = r_protocol_err;

endmodule
`default_nettype wire
